// File: rtl/display_buffer_ring.sv
// display_buffer_ring: NBUF-way frame buffer role manager (display / write / pending FIFO / free)
module display_buffer_ring #(
  parameter int NBUF = 3,
  parameter int IDX_W = 3
) (
  input  logic             CLOCK_33,
  input  logic             iRSTN,
  input  logic             iEnd_Frame,
  input  logic             iCtrl_WE,
  input  logic [31:0]      iCtrl_WD,
  output logic [IDX_W-1:0] oDisp_Idx,
  output logic [IDX_W-1:0] oWr_Idx,
  output logic             oWr_Ready,
  output logic             oSwap,
  output logic [31:0]      oStatus
);
  localparam logic [NBUF-1:0] FREE0 = ~NBUF'(3);
  logic [NBUF-1:0][IDX_W-1:0] q, n_q;
  logic [NBUF-1:0] free_m, n_free;
  logic [IDX_W-1:0] n_disp, n_wr;
  logic [2:0] cnt, n_cnt;
  logic [7:0] drop, n_drop;
  logic [11:0] swaps, n_swaps;
  logic n_rdy, mode, n_mode, err, n_err, n_swap, live;
  logic go_end, commit, mode_wr, clr_cnt, clr_err, unused_wd;
  // inputs are ignored on the first edge after reset release
  assign go_end = live & iEnd_Frame;
  assign commit = live & iCtrl_WE & iCtrl_WD[0];
  assign mode_wr = live & iCtrl_WE & iCtrl_WD[1];
  assign clr_cnt = live & iCtrl_WE & iCtrl_WD[3];
  assign clr_err = live & iCtrl_WE & iCtrl_WD[4];
  assign unused_wd = ^iCtrl_WD[31:5];
  assign oStatus = {swaps, drop, cnt, err, mode, oWr_Ready, oWr_Idx, oDisp_Idx};
  function automatic logic [NBUF-1:0] oh(input logic [IDX_W-1:0] idx);
    oh = '0;
    for (int i = 0; i < NBUF; i++) oh[i] = (IDX_W'(i) == idx);
  endfunction
  function automatic logic [IDX_W-1:0] low(input logic [NBUF-1:0] m);
    low = '0;
    for (int i = NBUF - 1; i >= 0; i--) if (m[i]) low = IDX_W'(i);
  endfunction
  // next state: swap first, refill a stalled writer, then commit, then control bits
  always_comb begin
    n_disp = oDisp_Idx;
    n_wr = oWr_Idx;
    n_rdy = oWr_Ready;
    n_q = q;
    n_cnt = cnt;
    n_free = free_m;
    n_mode = mode;
    n_err = err;
    n_drop = drop;
    n_swaps = swaps;
    n_swap = 1'b0;
    if (go_end && cnt != 3'd0) begin
      n_free = n_free | oh(oDisp_Idx);
      n_disp = q[0];
      for (int i = 0; i < NBUF - 1; i++) n_q[i] = q[i+1];
      n_q[NBUF-1] = '0;
      n_cnt = cnt - 3'd1;
      n_swaps = swaps + 12'd1;
      n_swap = 1'b1;
    end
    if (!n_rdy && |n_free) begin
      n_wr = low(n_free);
      n_free = n_free & ~oh(n_wr);
      n_rdy = 1'b1;
    end
    if (commit && n_rdy) begin
      if (!mode && n_cnt != 3'd0) begin
        n_free = n_free | oh(n_q[0]);
        n_q[0] = n_wr;
        n_drop = (drop == 8'hff) ? drop : drop + 8'd1;
      end else begin
        for (int i = 0; i < NBUF; i++) if (i == int'(n_cnt)) n_q[i] = n_wr;
        n_cnt = n_cnt + 3'd1;
      end
      n_rdy = |n_free;
      if (|n_free) begin
        n_wr = low(n_free);
        n_free = n_free & ~oh(n_wr);
      end
    end else if (commit) n_err = 1'b1;
    if (mode_wr) begin
      n_mode = (cnt == 3'd0) ? iCtrl_WD[2] : mode;
      n_err = n_err | (cnt != 3'd0);
    end
    if (clr_cnt) begin
      n_drop = '0;
      n_swaps = '0;
    end
    if (clr_err) n_err = 1'b0;
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge CLOCK_33 or negedge iRSTN) begin
    if (!iRSTN) begin
      oDisp_Idx <= '0;
      oWr_Idx <= IDX_W'(1);
      oWr_Ready <= 1'b1;
      oSwap <= 1'b0;
      q <= '0;
      cnt <= '0;
      free_m <= FREE0;
      mode <= 1'b0;
      err <= 1'b0;
      drop <= '0;
      swaps <= '0;
      live <= 1'b0;
    end else begin
      oDisp_Idx <= n_disp;
      oWr_Idx <= n_wr;
      oWr_Ready <= n_rdy;
      oSwap <= n_swap;
      q <= n_q;
      cnt <= n_cnt;
      free_m <= n_free;
      mode <= n_mode;
      err <= n_err;
      drop <= n_drop;
      swaps <= n_swaps;
      live <= 1'b1;
    end
  end
endmodule

// File: tb/tb_display_buffer_ring.sv
// tb_display_buffer_ring: NBUF=2/3/4 instances checked against a role-set reference model
module tb_display_buffer_ring;
  logic clk = 1'b0;
  logic iRSTN = 1'b0;
  logic iEnd_Frame = 1'b0;
  logic iCtrl_WE = 1'b0;
  logic [31:0] iCtrl_WD = '0;
  logic [2:0] disp_o[3], wr_o[3];
  logic rdy_o[3], sw_o[3];
  logic [31:0] st_o[3];
  int n_cmp = 0, n_bad = 0;
  int nb[3] = '{2, 3, 4};
  int m_disp[3], m_wr[3], m_rdy[3], m_mode[3], m_err[3], m_drop[3], m_swc[3], m_sw[3], m_pc[3];
  int m_pend[3][8];
  bit m_live;

  always #5 clk = ~clk;

  display_buffer_ring #(.NBUF(2), .IDX_W(3)) u2 (.CLOCK_33(clk), .iRSTN(iRSTN), .iEnd_Frame(iEnd_Frame),
    .iCtrl_WE(iCtrl_WE), .iCtrl_WD(iCtrl_WD), .oDisp_Idx(disp_o[0]), .oWr_Idx(wr_o[0]),
    .oWr_Ready(rdy_o[0]), .oSwap(sw_o[0]), .oStatus(st_o[0]));
  display_buffer_ring #(.NBUF(3), .IDX_W(3)) u3 (.CLOCK_33(clk), .iRSTN(iRSTN), .iEnd_Frame(iEnd_Frame),
    .iCtrl_WE(iCtrl_WE), .iCtrl_WD(iCtrl_WD), .oDisp_Idx(disp_o[1]), .oWr_Idx(wr_o[1]),
    .oWr_Ready(rdy_o[1]), .oSwap(sw_o[1]), .oStatus(st_o[1]));
  display_buffer_ring #(.NBUF(4), .IDX_W(3)) u4 (.CLOCK_33(clk), .iRSTN(iRSTN), .iEnd_Frame(iEnd_Frame),
    .iCtrl_WE(iCtrl_WE), .iCtrl_WD(iCtrl_WD), .oDisp_Idx(disp_o[2]), .oWr_Idx(wr_o[2]),
    .oWr_Ready(rdy_o[2]), .oSwap(sw_o[2]), .oStatus(st_o[2]));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // lowest buffer that is neither displayed, owned by the writer, nor pending
  function automatic int lowest(int k);
    for (int b = 0; b < nb[k]; b++) begin
      bit used = (b == m_disp[k]) || (m_rdy[k] != 0 && b == m_wr[k]);
      for (int i = 0; i < m_pc[k]; i++) if (m_pend[k][i] == b) used = 1;
      if (!used) return b;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_live = 0;
    for (int k = 0; k < 3; k++) begin
      m_disp[k] = 0; m_wr[k] = 1; m_rdy[k] = 1; m_mode[k] = 0; m_err[k] = 0;
      m_drop[k] = 0; m_swc[k] = 0; m_sw[k] = 0; m_pc[k] = 0;
      for (int i = 0; i < 8; i++) m_pend[k][i] = 0;
    end
  endtask

  task automatic m_step(int k, bit e, bit we, logic [31:0] wd);
    int pc0 = m_pc[k];
    int f;
    m_sw[k] = 0;
    if (e && m_pc[k] > 0) begin
      m_disp[k] = m_pend[k][0];
      for (int i = 0; i < 7; i++) m_pend[k][i] = m_pend[k][i+1];
      m_pc[k]--;
      m_swc[k] = (m_swc[k] + 1) % 4096;
      m_sw[k] = 1;
    end
    if (m_rdy[k] == 0) begin
      f = lowest(k);
      if (f >= 0) begin m_wr[k] = f; m_rdy[k] = 1; end
    end
    if (we && wd[0]) begin
      if (m_rdy[k] != 0) begin
        if (m_mode[k] == 0 && m_pc[k] > 0) begin
          m_pend[k][0] = m_wr[k];
          m_drop[k] = (m_drop[k] < 255) ? m_drop[k] + 1 : 255;
        end else begin
          m_pend[k][m_pc[k]] = m_wr[k];
          m_pc[k]++;
        end
        m_rdy[k] = 0;
        f = lowest(k);
        if (f >= 0) begin m_wr[k] = f; m_rdy[k] = 1; end
      end else m_err[k] = 1;
    end
    if (we && wd[1]) begin
      if (pc0 == 0) m_mode[k] = int'(wd[2]);
      else m_err[k] = 1;
    end
    if (we && wd[3]) begin m_drop[k] = 0; m_swc[k] = 0; end
    if (we && wd[4]) m_err[k] = 0;
  endtask

  always @(posedge clk) begin
    if (!iRSTN) m_reset();
    else if (!m_live) m_live = 1;
    else for (int k = 0; k < 3; k++) m_step(k, iEnd_Frame, iCtrl_WE, iCtrl_WD);
  end

  function automatic logic [31:0] m_status(int k);
    return 32'(m_disp[k] + (m_wr[k] << 3) + (m_rdy[k] << 6) + (m_mode[k] << 7) + (m_err[k] << 8)
             + (m_pc[k] << 9) + (m_drop[k] << 12) + (m_swc[k] << 20));
  endfunction

  task automatic cmp_model();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("n%0d disp", nb[k]), 32'(disp_o[k]), 32'(m_disp[k]));
      check($sformatf("n%0d wr", nb[k]), 32'(wr_o[k]), 32'(m_wr[k]));
      check($sformatf("n%0d rdy", nb[k]), 32'(rdy_o[k]), 32'(m_rdy[k]));
      check($sformatf("n%0d swap", nb[k]), 32'(sw_o[k]), 32'(m_sw[k]));
      check($sformatf("n%0d status", nb[k]), st_o[k], m_status(k));
    end
  endtask

  task automatic cyc(bit e, bit we, logic [31:0] wd);
    iEnd_Frame = e; iCtrl_WE = we; iCtrl_WD = wd;
    @(negedge clk);
    iEnd_Frame = 0; iCtrl_WE = 0; iCtrl_WD = '0;
    cmp_model();
  endtask

  task automatic do_reset();
    iRSTN = 0;
    @(negedge clk);
    cmp_model();
    for (int k = 0; k < 3; k++) check($sformatf("n%0d reset status", nb[k]), st_o[k], 32'h48);
    iRSTN = 1; iCtrl_WE = 1; iCtrl_WD = 32'h1;
    @(negedge clk);
    iCtrl_WE = 0; iCtrl_WD = '0;
    check("release commit ignored", {29'd0, wr_o[1]}, 32'd1);
    cmp_model();
  endtask

  initial begin
    logic [31:0] wd, st;
    @(negedge clk);
    do_reset();
    cyc(0, 1, 1);
    check("t1 wr", 32'(wr_o[1]), 2);
    check("t1 pending", 32'(st_o[1][11:9]), 1);
    cyc(1, 0, 0);
    check("t1 disp", 32'(disp_o[1]), 1);
    check("t1 swap pulse", 32'(sw_o[1]), 1);
    check("t1 swap_cnt", 32'(st_o[1][31:20]), 1);
    cyc(0, 0, 0);
    check("t1 swap low", 32'(sw_o[1]), 0);
    cyc(0, 1, 1);
    check("t1 buf0 free", 32'(wr_o[1]), 0);
    do_reset();
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    check("t2 drop", 32'(st_o[1][19:12]), 1);
    check("t2 pending", 32'(st_o[1][11:9]), 1);
    check("t2 wr", 32'(wr_o[1]), 1);
    check("t2 rdy", 32'(rdy_o[1]), 1);
    cyc(1, 0, 0);
    check("t2 disp", 32'(disp_o[1]), 2);
    do_reset();
    cyc(0, 1, 6);
    check("t3 mode", 32'(st_o[2][7]), 1);
    repeat (3) cyc(0, 1, 1);
    check("t3 pending", 32'(st_o[2][11:9]), 3);
    check("t3 rdy", 32'(rdy_o[2]), 0);
    st = st_o[2];
    cyc(0, 1, 1);
    check("t3 stall status", st_o[2], st | 32'h100);
    cyc(1, 0, 0);
    check("t3 disp", 32'(disp_o[2]), 1);
    check("t3 wr", 32'(wr_o[2]), 0);
    check("t3 rdy after", 32'(rdy_o[2]), 1);
    cyc(1, 0, 0);
    check("t3 order2", 32'(disp_o[2]), 2);
    cyc(1, 0, 0);
    check("t3 order3", 32'(disp_o[2]), 3);
    do_reset();
    cyc(0, 1, 1);
    check("t4 stall", 32'(rdy_o[0]), 0);
    cyc(1, 1, 1);
    check("t4 disp", 32'(disp_o[0]), 1);
    check("t4 pending", 32'(st_o[0][11:9]), 1);
    check("t4 rdy", 32'(rdy_o[0]), 0);
    check("t4 drop", 32'(st_o[0][19:12]), 0);
    check("t4 err", 32'(st_o[0][8]), 0);
    cyc(1, 0, 0);
    check("t4 buf0 pushed", 32'(disp_o[0]), 0);
    do_reset();
    cyc(0, 1, 1);
    cyc(0, 1, 6);
    check("t5 cmd_err", 32'(st_o[1][8]), 1);
    check("t5 mode kept", 32'(st_o[1][7]), 0);
    cyc(0, 1, 16);
    check("t5 err clear", 32'(st_o[1][8]), 0);
    do_reset();
    cyc(0, 1, 1);
    repeat (4097) cyc(1, 1, 1);
    for (int k = 0; k < 3; k++) check($sformatf("n%0d swap wrap", nb[k]), 32'(st_o[k][31:20]), 1);
    do_reset();
    repeat (301) cyc(0, 1, 1);
    check("t7 drop sat", 32'(st_o[1][19:12]), 255);
    check("t7 drop sat n4", 32'(st_o[2][19:12]), 255);
    do_reset();
    repeat (3000) begin
      wd = $urandom;
      wd[1] = ($urandom % 8 == 0);
      wd[3] = ($urandom % 32 == 0);
      wd[4] = ($urandom % 8 == 0);
      cyc($urandom % 4 == 0, $urandom % 2 == 0, wd);
    end
    #3 iRSTN = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("n%0d async disp", nb[k]), 32'(disp_o[k]), 0);
      check($sformatf("n%0d async swap", nb[k]), 32'(sw_o[k]), 0);
      check($sformatf("n%0d async status", nb[k]), st_o[k], 32'h48);
    end
    @(negedge clk);
    do_reset();
    repeat (200) cyc($urandom % 3 == 0, $urandom % 2 == 0, $urandom & 32'h1d);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
